pixel_scan_generator: RTL

PIXEL_SCAN_GENERATOR -- requirements
Module: pixel_scan_generator

---
 rtl/pixel_scan_generator_pkg.sv | 16 +
 rtl/pixel_scan_generator_axis.sv | 30 +++
 rtl/pixel_scan_generator.sv | 96 +++++++++
 3 files changed

// File: rtl/pixel_scan_generator_pkg.sv
// Shared display package: screen geometry, coordinate widths and the scan
// FSM state type. The arc point generator imports this package as well.
package pixel_scan_generator_pkg;

    localparam int unsigned SCREEN_W = 240;
    localparam int unsigned SCREEN_H = 320;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 9;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE = 2'd0;
    localparam scan_state_t ST_SCAN = 2'd1;
    localparam scan_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/pixel_scan_generator_axis.sv
// scan_axis_counter: one scan axis (row or column). Loads MIN, steps by one
// on inc and wraps from MAX back to MIN; at_max flags the last position.
module scan_axis_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MIN = 0,
    parameter int unsigned MAX = 239
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         at_max
);

    localparam logic [W-1:0] MIN_V = W'(MIN);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    assign at_max = (value == MAX_V);

    // Position register: reset/load to MIN, step or wrap on inc.
    always_ff @(posedge clock) begin
        if (reset || load) begin
            value <= MIN_V;
        end else if (inc) begin
            value <= at_max ? MIN_V : value + W'(1);
        end
    end

endmodule

// File: rtl/pixel_scan_generator.sv
// pixel_scan_generator: raster scan of a rectangular window, one coordinate
// per valid/ready handshake, with a one-cycle frame_done pulse at the end.
// Optional feature: define SCAN_CONTINUOUS_EN to restart the scan right
// after each frame_done instead of returning to idle.
module pixel_scan_generator
    import pixel_scan_generator_pkg::*;
#(
    parameter int unsigned X_MIN = 0,
    parameter int unsigned X_MAX = SCREEN_W - 1,
    parameter int unsigned Y_MIN = 0,
    parameter int unsigned Y_MAX = SCREEN_H - 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           pixel_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pixel_valid,
    output logic           busy,
    output logic           frame_done
);

    scan_state_t state;
    scan_state_t state_next;

    logic handshake;
    logic x_at_max;
    logic y_at_max;
    logic last_pixel;
    logic load;

    assign pixel_valid = (state == ST_SCAN);
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_DONE);

    assign handshake  = pixel_valid & pixel_ready;
    assign last_pixel = handshake & x_at_max & y_at_max;

`ifdef SCAN_CONTINUOUS_EN
    assign load = ((state == ST_IDLE) && start) || (state == ST_DONE);
`else
    assign load = (state == ST_IDLE) && start;
`endif

    scan_axis_counter #(
        .W   (X_W),
        .MIN (X_MIN),
        .MAX (X_MAX)
    ) u_x_counter (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .inc    (handshake),
        .value  (x),
        .at_max (x_at_max)
    );

    scan_axis_counter #(
        .W   (Y_W),
        .MIN (Y_MIN),
        .MAX (Y_MAX)
    ) u_y_counter (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .inc    (handshake & x_at_max),
        .value  (y),
        .at_max (y_at_max)
    );

    // Next-state logic: start only matters in idle; DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_SCAN;
            ST_SCAN: if (last_pixel) state_next = ST_DONE;
`ifdef SCAN_CONTINUOUS_EN
            ST_DONE: state_next = ST_SCAN;
`else
            ST_DONE: state_next = ST_IDLE;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

endmodule
